// File: rtl/reg_file_sb_if.sv
// Datapath-side bus of the scoreboarded register file: decode reads and reservations,
// writeback writes, and the clear-engine handshake.
interface reg_file_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] R1;
  logic [ADDR_W-1:0] R2;
  logic [DATA_W-1:0] s1;
  logic [DATA_W-1:0] s2;
  logic              busy1;
  logic              busy2;
  logic [ADDR_W-1:0] RD;
  logic [DATA_W-1:0] WRD;
  logic              Wreg;
  logic              rsv_en;
  logic [ADDR_W-1:0] rsv_addr;
  logic              clr_req;
  logic              clr_busy;

  modport master (
    output R1, R2, RD, WRD, Wreg, rsv_en, rsv_addr, clr_req,
    input  s1, s2, busy1, busy2, clr_busy
  );

  modport slave (
    input  R1, R2, RD, WRD, Wreg, rsv_en, rsv_addr, clr_req,
    output s1, s2, busy1, busy2, clr_busy
  );
endinterface

// File: rtl/reg_file_sb.sv
// Register file with two async read ports, one sync write port, optional bypass and
// hardwired zero, a per-register busy scoreboard and a one-entry-per-cycle clear engine.
module reg_file_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input logic         clk,
  input logic         reset,
  reg_file_sb_if.slave bus
);

  typedef enum logic {IDLE, CLEAR} state_t;

  localparam logic [ADDR_W:0]   NUM_REGS_W = (ADDR_W+1)'(NUM_REGS);
  localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NUM_REGS - 1);

  state_t              state;
  logic [ADDR_W-1:0]   idx;
  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;

  logic wr_ok;
  logic fwd1;
  logic fwd2;

  // An address is writable when it is in range and not the hardwired zero register.
  function automatic logic writable(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < NUM_REGS_W) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign wr_ok = (state == IDLE) && bus.Wreg && writable(bus.RD);
  assign fwd1  = (BYPASS != 0) && wr_ok && (bus.RD == bus.R1);
  assign fwd2  = (BYPASS != 0) && wr_ok && (bus.RD == bus.R2);

  assign bus.clr_busy = (state == CLEAR);

  always_comb begin
    bus.s1    = '0;
    bus.s2    = '0;
    bus.busy1 = 1'b0;
    bus.busy2 = 1'b0;
    if (!reset && state == IDLE) begin
      if (writable(bus.R1)) begin
        bus.s1    = fwd1 ? bus.WRD : regs[bus.R1];
        bus.busy1 = busy[bus.R1] & ~fwd1;
      end
      if (writable(bus.R2)) begin
        bus.s2    = fwd2 ? bus.WRD : regs[bus.R2];
        bus.busy2 = busy[bus.R2] & ~fwd2;
      end
    end
  end

  // Reservation is applied after the writeback release so a new producer on the same
  // register keeps it busy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
      busy  <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (wr_ok) begin
            regs[bus.RD] <= bus.WRD;
            busy[bus.RD] <= 1'b0;
          end
          if (bus.rsv_en && writable(bus.rsv_addr)) begin
            busy[bus.rsv_addr] <= 1'b1;
          end
          if (bus.clr_req) begin
            state <= CLEAR;
            idx   <= '0;
          end
        end
        CLEAR: begin
          regs[idx] <= '0;
          busy[idx] <= 1'b0;
          if (idx == LAST_IDX) begin
            state <= IDLE;
            idx   <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          idx   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed self-checking bench for reg_file_sb; a second BYPASS=0 instance mirrors the
// same stimulus to show the non-forwarded read behaviour.
module tb_reg_file_sb;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  reg_file_sb_if #(.DATA_W(32), .ADDR_W(5)) ifa ();
  reg_file_sb_if #(.DATA_W(32), .ADDR_W(5)) ifn ();

  reg_file_sb #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk), .reset(reset), .bus(ifa)
  );

  reg_file_sb #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32), .ZERO_REG(1), .BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .bus(ifn)
  );

  assign ifn.R1       = ifa.R1;
  assign ifn.R2       = ifa.R2;
  assign ifn.RD       = ifa.RD;
  assign ifn.WRD      = ifa.WRD;
  assign ifn.Wreg     = ifa.Wreg;
  assign ifn.rsv_en   = ifa.rsv_en;
  assign ifn.rsv_addr = ifa.rsv_addr;
  assign ifn.clr_req  = ifa.clr_req;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change at the falling edge; the design commits on the following rising edge.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ifa.R1 = 5'd3; ifa.R2 = 5'd31;
    #3;
    checks++; if (ifa.s1 !== 32'h0) begin errors++; $display("[TB] FAIL reset_s1 got %h want 0", ifa.s1); end
    checks++; if (ifa.s2 !== 32'h0) begin errors++; $display("[TB] FAIL reset_s2 got %h want 0", ifa.s2); end
    checks++; if (ifa.busy1 !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy1 got %b want 0", ifa.busy1); end
    checks++; if (ifa.busy2 !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy2 got %b want 0", ifa.busy2); end
    checks++; if (ifa.clr_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_clr_busy got %b want 0", ifa.clr_busy); end
    next_cycle();
    reset = 1'b0;
    next_cycle();
  endtask

  task automatic test_write_read();
    ifa.Wreg = 1'b1; ifa.RD = 5'd5; ifa.WRD = 32'hDEADBEEF; ifa.R1 = 5'd0;
    next_cycle();
    ifa.Wreg = 1'b0; ifa.R1 = 5'd5;
    #1;
    checks++; if (ifa.s1 !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL write_read_r5 got %h want deadbeef", ifa.s1); end
    ifa.Wreg = 1'b1; ifa.RD = 5'd0; ifa.WRD = 32'h1234; ifa.R2 = 5'd0;
    #1;
    checks++; if (ifa.s2 !== 32'h0) begin errors++; $display("[TB] FAIL r0_no_bypass got %h want 0", ifa.s2); end
    next_cycle();
    ifa.Wreg = 1'b0;
    #1;
    checks++; if (ifa.s2 !== 32'h0) begin errors++; $display("[TB] FAIL r0_write_ignored got %h want 0", ifa.s2); end
    checks++; if (ifa.s1 !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL r5_retained got %h want deadbeef", ifa.s1); end
  endtask

  task automatic test_bypass();
    ifa.Wreg = 1'b1; ifa.RD = 5'd7; ifa.WRD = 32'h11111111;
    next_cycle();
    ifa.Wreg = 1'b0; ifa.rsv_en = 1'b1; ifa.rsv_addr = 5'd7;
    next_cycle();
    ifa.rsv_en = 1'b0;
    ifa.Wreg = 1'b1; ifa.RD = 5'd7; ifa.WRD = 32'hA5A5A5A5; ifa.R1 = 5'd7;
    #1;
    checks++; if (ifa.s1 !== 32'hA5A5A5A5) begin errors++; $display("[TB] FAIL bypass_s1 got %h want a5a5a5a5", ifa.s1); end
    checks++; if (ifa.busy1 !== 1'b0) begin errors++; $display("[TB] FAIL bypass_busy1 got %b want 0", ifa.busy1); end
    checks++; if (ifn.s1 !== 32'h11111111) begin errors++; $display("[TB] FAIL nobypass_s1 got %h want 11111111", ifn.s1); end
    checks++; if (ifn.busy1 !== 1'b1) begin errors++; $display("[TB] FAIL nobypass_busy1 got %b want 1", ifn.busy1); end
    next_cycle();
    ifa.Wreg = 1'b0;
    #1;
    checks++; if (ifa.s1 !== 32'hA5A5A5A5) begin errors++; $display("[TB] FAIL bypass_after_s1 got %h want a5a5a5a5", ifa.s1); end
    checks++; if (ifn.s1 !== 32'hA5A5A5A5) begin errors++; $display("[TB] FAIL nobypass_after_s1 got %h want a5a5a5a5", ifn.s1); end
  endtask

  task automatic test_scoreboard();
    ifa.R2 = 5'd9; ifa.rsv_en = 1'b1; ifa.rsv_addr = 5'd9;
    #1;
    checks++; if (ifa.busy2 !== 1'b0) begin errors++; $display("[TB] FAIL sb_before_rsv got %b want 0", ifa.busy2); end
    next_cycle();
    ifa.rsv_en = 1'b0;
    #1;
    checks++; if (ifa.busy2 !== 1'b1) begin errors++; $display("[TB] FAIL sb_reserved got %b want 1", ifa.busy2); end
    ifa.Wreg = 1'b1; ifa.RD = 5'd9; ifa.WRD = 32'h99;
    next_cycle();
    ifa.Wreg = 1'b0;
    #1;
    checks++; if (ifa.busy2 !== 1'b0) begin errors++; $display("[TB] FAIL sb_released got %b want 0", ifa.busy2); end
    ifa.rsv_en = 1'b1; ifa.rsv_addr = 5'd9; ifa.Wreg = 1'b1; ifa.RD = 5'd9; ifa.WRD = 32'h999;
    next_cycle();
    ifa.rsv_en = 1'b0; ifa.Wreg = 1'b0;
    #1;
    checks++; if (ifa.busy2 !== 1'b1) begin errors++; $display("[TB] FAIL sb_set_wins got %b want 1", ifa.busy2); end
    checks++; if (ifa.s2 !== 32'h999) begin errors++; $display("[TB] FAIL sb_same_edge_write got %h want 999", ifa.s2); end
  endtask

  task automatic test_clear();
    int cnt;
    ifa.rsv_en = 1'b1; ifa.rsv_addr = 5'd12;
    for (int r = 1; r < 32; r++) begin
      ifa.Wreg = 1'b1; ifa.RD = r[4:0]; ifa.WRD = 32'hFFFFFFFF;
      next_cycle();
    end
    ifa.Wreg = 1'b0; ifa.rsv_en = 1'b0; ifa.R1 = 5'd31; ifa.R2 = 5'd12;
    #1;
    checks++; if (ifa.s1 !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL fill_r31 got %h want ffffffff", ifa.s1); end
    checks++; if (ifa.busy2 !== 1'b1) begin errors++; $display("[TB] FAIL fill_busy12 got %b want 1", ifa.busy2); end
    ifa.clr_req = 1'b1;
    next_cycle();
    ifa.clr_req = 1'b0;
    ifa.Wreg = 1'b1; ifa.RD = 5'd3; ifa.WRD = 32'h55;
    ifa.rsv_en = 1'b1; ifa.rsv_addr = 5'd4;
    #1;
    checks++; if (ifa.clr_busy !== 1'b1) begin errors++; $display("[TB] FAIL clr_started got %b want 1", ifa.clr_busy); end
    checks++; if (ifa.s1 !== 32'h0) begin errors++; $display("[TB] FAIL clr_s1_gated got %h want 0", ifa.s1); end
    checks++; if (ifa.busy2 !== 1'b0) begin errors++; $display("[TB] FAIL clr_busy2_gated got %b want 0", ifa.busy2); end
    cnt = 0;
    while (ifa.clr_busy === 1'b1 && cnt < 100) begin
      cnt++;
      next_cycle();
    end
    ifa.Wreg = 1'b0; ifa.rsv_en = 1'b0;
    checks++; if (cnt != 32) begin errors++; $display("[TB] FAIL clr_duration got %0d want 32", cnt); end
    for (int r = 0; r < 32; r++) begin
      ifa.R1 = r[4:0];
      #1;
      checks++; if (ifa.s1 !== 32'h0) begin errors++; $display("[TB] FAIL clr_reg%0d got %h want 0", r, ifa.s1); end
      checks++; if (ifa.busy1 !== 1'b0) begin errors++; $display("[TB] FAIL clr_busy%0d got %b want 0", r, ifa.busy1); end
    end
    next_cycle();
  endtask

  task automatic test_reset_mid_clear();
    ifa.Wreg = 1'b1; ifa.RD = 5'd20; ifa.WRD = 32'hCAFE;
    ifa.rsv_en = 1'b1; ifa.rsv_addr = 5'd25;
    next_cycle();
    ifa.Wreg = 1'b0; ifa.rsv_en = 1'b0;
    ifa.clr_req = 1'b1;
    next_cycle();
    ifa.clr_req = 1'b0;
    repeat (10) next_cycle();
    ifa.R1 = 5'd20; ifa.R2 = 5'd25;
    #1;
    checks++; if (ifa.clr_busy !== 1'b1) begin errors++; $display("[TB] FAIL midclr_running got %b want 1", ifa.clr_busy); end
    reset = 1'b1;
    #1;
    checks++; if (ifa.clr_busy !== 1'b0) begin errors++; $display("[TB] FAIL midclr_reset_clr_busy got %b want 0", ifa.clr_busy); end
    next_cycle();
    reset = 1'b0;
    #1;
    checks++; if (ifa.s1 !== 32'h0) begin errors++; $display("[TB] FAIL midclr_r20 got %h want 0", ifa.s1); end
    checks++; if (ifa.busy2 !== 1'b0) begin errors++; $display("[TB] FAIL midclr_busy25 got %b want 0", ifa.busy2); end
    ifa.Wreg = 1'b1; ifa.RD = 5'd6; ifa.WRD = 32'h600D;
    next_cycle();
    ifa.Wreg = 1'b0; ifa.R1 = 5'd6;
    #1;
    checks++; if (ifa.clr_busy !== 1'b0) begin errors++; $display("[TB] FAIL midclr_idle got %b want 0", ifa.clr_busy); end
    checks++; if (ifa.s1 !== 32'h600D) begin errors++; $display("[TB] FAIL midclr_write_after got %h want 600d", ifa.s1); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b1;
    ifa.R1 = '0; ifa.R2 = '0; ifa.RD = '0; ifa.WRD = '0; ifa.Wreg = 1'b0;
    ifa.rsv_en = 1'b0; ifa.rsv_addr = '0; ifa.clr_req = 1'b0;
    test_reset();
    test_write_read();
    test_bypass();
    test_scoreboard();
    test_clear();
    test_reset_mid_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
